fpga_rst_seq: RTL and testbench

Parametrised reset sequencer and status driver for the FPGA top level. It filters the PLL lock, releases a debug-module reset and then N SoC reset domains in a staged order. It re-enters reset on lock loss, debugger ndmreset or software reset request, and exposes state, a heartbeat LED and a lock-loss counter. It sits between the board clock/PLL logic and ara_soc, dm_top and the peripherals.

---
 rtl/fpga_rst_seq.sv | 183 ++++++++++++++++++
 tb/tb_fpga_rst_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_rst_seq.sv
// ============================================================================
// fpga_rst_seq : PLL-lock filtered, staged reset sequencer with status outputs
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fpga_rst_seq #(
  parameter int NrRstOut = 3,
  parameter int LockFilt = 64,
  parameter int RelDelay = 16,
  parameter int HoldMin  = 32,
  parameter int HbDiv    = 12_500_000
) (
  input  logic                core_clk,
  input  logic                sys_rst_n,
  input  logic                pll_locked_i,
  input  logic                ndmreset_i,
  input  logic                sw_rst_req_i,
  output logic                dm_rst_no,
  output logic [NrRstOut-1:0] rst_no,
  output logic [2:0]          state_o,
  output logic                heartbeat_o,
  output logic [7:0]          lock_lost_cnt_o
);

  localparam int MaxFr  = (LockFilt > RelDelay) ? LockFilt : RelDelay;
  localparam int MaxFrh = (MaxFr > HoldMin) ? MaxFr : HoldMin;
  localparam int MaxCnt = (MaxFrh > HbDiv) ? MaxFrh : HbDiv;
  localparam int CntW   = $clog2(MaxCnt);
  localparam int StgW   = (NrRstOut > 1) ? $clog2(NrRstOut) : 1;

  localparam logic [CntW-1:0] FiltLast = CntW'(LockFilt - 1);
  localparam logic [CntW-1:0] RelLast  = CntW'(RelDelay - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldMin - 1);
  localparam logic [CntW-1:0] HbLast   = CntW'(HbDiv - 1);
  localparam logic [StgW-1:0] StgLast  = StgW'(NrRstOut - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic                lock_meta, lock_s;
  logic [CntW-1:0]     cnt, cnt_nxt;
  logic [StgW-1:0]     stg, stg_nxt;
  logic                dm_rst_n, dm_rst_n_nxt;
  logic [NrRstOut-1:0] rst_n, rst_n_nxt;
  logic                hb, hb_nxt;
  logic [7:0]          lost_cnt, lost_cnt_nxt;
  logic                lose_lock, enter_hold;

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      state     <= WAIT_LOCK;
      cnt       <= '0;
      stg       <= '0;
      dm_rst_n  <= 1'b0;
      rst_n     <= '0;
      hb        <= 1'b0;
      lost_cnt  <= 8'd0;
    end else begin
      lock_meta <= pll_locked_i;
      lock_s    <= lock_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stg       <= stg_nxt;
      dm_rst_n  <= dm_rst_n_nxt;
      rst_n     <= rst_n_nxt;
      hb        <= hb_nxt;
      lost_cnt  <= lost_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stg_nxt      = stg;
    dm_rst_n_nxt = dm_rst_n;
    rst_n_nxt    = rst_n;
    hb_nxt       = hb;
    lost_cnt_nxt = lost_cnt;
    lose_lock    = ((state == RELEASE) || (state == RUN) || (state == HOLD)) && !lock_s;
    enter_hold   = ((state == RELEASE) || (state == RUN)) && (ndmreset_i || sw_rst_req_i);

    unique case (state)
      WAIT_LOCK: begin
        dm_rst_n_nxt = 1'b0;
        rst_n_nxt    = '0;
        hb_nxt       = 1'b0;
        cnt_nxt      = '0;
        if (lock_s) state_nxt = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == FiltLast) begin
          dm_rst_n_nxt = 1'b1;
          state_nxt    = RELEASE;
          cnt_nxt      = '0;
          stg_nxt      = '0;
        end else begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      RELEASE: begin
        if (cnt == RelLast) begin
          for (int i = 0; i < NrRstOut; i++) begin
            if (stg == StgW'(i)) rst_n_nxt[i] = 1'b1;
          end
          cnt_nxt = '0;
          if (stg == StgLast) state_nxt = RUN;
          else                stg_nxt   = stg + StgW'(1);
        end else begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      RUN: begin
        if (cnt == HbLast) begin
          hb_nxt  = !hb;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      HOLD: begin
        // A fresh software request re-arms the full minimum hold time.
        if (sw_rst_req_i) begin
          cnt_nxt = '0;
        end else if (cnt == HoldLast) begin
          if (!ndmreset_i) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            stg_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      default: begin
        state_nxt    = WAIT_LOCK;
        cnt_nxt      = '0;
        stg_nxt      = '0;
        dm_rst_n_nxt = 1'b0;
        rst_n_nxt    = '0;
        hb_nxt       = 1'b0;
      end
    endcase

    // Later overrides win: lock loss outranks a hold request.
    if (enter_hold) begin
      state_nxt = HOLD;
      rst_n_nxt = '0;
      cnt_nxt   = '0;
      hb_nxt    = 1'b0;
    end
    if (lose_lock) begin
      state_nxt    = WAIT_LOCK;
      cnt_nxt      = '0;
      stg_nxt      = '0;
      dm_rst_n_nxt = 1'b0;
      rst_n_nxt    = '0;
      hb_nxt       = 1'b0;
      if (lost_cnt != 8'hFF) lost_cnt_nxt = lost_cnt + 8'd1;
    end
  end

  assign state_o         = state;
  assign dm_rst_no       = dm_rst_n;
  assign rst_no          = rst_n;
  assign heartbeat_o     = hb;
  assign lock_lost_cnt_o = lost_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fpga_rst_seq.sv
// ============================================================================
// tb_fpga_rst_seq : scoreboard bench for fpga_rst_seq with directed scenarios
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fpga_rst_seq;

  logic       core_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_locked_i = 1'b1;
  logic       ndmreset_i = 1'b0;
  logic       sw_rst_req_i = 1'b0;
  logic       dm_rst_no;
  logic [2:0] rst_no;
  logic [2:0] state_o;
  logic       heartbeat_o;
  logic [7:0] lock_lost_cnt_o;

  fpga_rst_seq #(
    .NrRstOut(3), .LockFilt(8), .RelDelay(4), .HoldMin(4), .HbDiv(5)
  ) dut (
    .core_clk        (core_clk),
    .sys_rst_n       (sys_rst_n),
    .pll_locked_i    (pll_locked_i),
    .ndmreset_i      (ndmreset_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .dm_rst_no       (dm_rst_no),
    .rst_no          (rst_no),
    .state_o         (state_o),
    .heartbeat_o     (heartbeat_o),
    .lock_lost_cnt_o (lock_lost_cnt_o)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    int         cyc;
    byte        ph;
    logic [2:0] st;
    logic       dm;
    logic [2:0] rs;
    logic       hb;
    logic [7:0] lost;
  } exp_t;

  exp_t sb_q[$];
  exp_t async_q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge core_clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int d, input byte ph, input logic [2:0] st, input logic dm,
                              input logic [2:0] rs, input logic hb, input logic [7:0] lost);
    exp_t e;
    e.cyc = cyc + d; e.ph = ph; e.st = st; e.dm = dm; e.rs = rs; e.hb = hb; e.lost = lost;
    return e;
  endfunction

  task automatic push(input int d, input byte ph, input logic [2:0] st, input logic dm,
                      input logic [2:0] rs, input logic hb, input logic [7:0] lost);
    sb_q.push_back(mk(d, ph, st, dm, rs, hb, lost));
  endtask

  task automatic compare(input exp_t e);
    total++;
    if ({state_o, dm_rst_no, rst_no, heartbeat_o, lock_lost_cnt_o} ===
        {e.st, e.dm, e.rs, e.hb, e.lost}) begin
      passed++;
    end else begin
      $display("FAIL %c@%0d: got st=%0d dm=%b rst=%b hb=%b lost=%0d, want st=%0d dm=%b rst=%b hb=%b lost=%0d",
               e.ph, cyc, state_o, dm_rst_no, rst_no, heartbeat_o, lock_lost_cnt_o,
               e.st, e.dm, e.rs, e.hb, e.lost);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge core_clk);
  endtask

  // Cycle-tagged monitor: checks each expectation on the cycle it was booked for.
  initial begin
    exp_t e;
    forever begin
      @(negedge core_clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          total++;
          $display("FAIL %c@%0d: check booked for cycle %0d was missed", e.ph, cyc, e.cyc);
        end else begin
          compare(e);
        end
      end
    end
  end

  // Asynchronous-reset monitor: samples shortly after sys_rst_n falls, between clock edges.
  initial begin
    forever begin
      @(negedge sys_rst_n);
      #1;
      if (async_q.size() > 0) compare(async_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, m, p, q, r, s, g;
    exp_t e;

    // Reset state, PLL already locked
    @(negedge core_clk);
    push(1, "R", 3'd0, 1'b0, 3'b000, 1'b0, 8'd0);
    push(2, "R", 3'd0, 1'b0, 3'b000, 1'b0, 8'd0);
    wait_cyc(3);
    sys_rst_n = 1'b1;

    // Power-up sequencing and first heartbeat toggles
    n = cyc;
    push(2,  "A", 3'd0, 1'b0, 3'b000, 1'b0, 8'd0);
    push(3,  "A", 3'd1, 1'b0, 3'b000, 1'b0, 8'd0);
    push(10, "A", 3'd1, 1'b0, 3'b000, 1'b0, 8'd0);
    push(11, "A", 3'd2, 1'b1, 3'b000, 1'b0, 8'd0);
    push(14, "A", 3'd2, 1'b1, 3'b000, 1'b0, 8'd0);
    push(15, "A", 3'd2, 1'b1, 3'b001, 1'b0, 8'd0);
    push(19, "A", 3'd2, 1'b1, 3'b011, 1'b0, 8'd0);
    push(22, "A", 3'd2, 1'b1, 3'b011, 1'b0, 8'd0);
    push(23, "A", 3'd3, 1'b1, 3'b111, 1'b0, 8'd0);
    push(27, "A", 3'd3, 1'b1, 3'b111, 1'b0, 8'd0);
    push(28, "A", 3'd3, 1'b1, 3'b111, 1'b1, 8'd0);
    push(32, "A", 3'd3, 1'b1, 3'b111, 1'b1, 8'd0);
    push(33, "A", 3'd3, 1'b1, 3'b111, 1'b0, 8'd0);
    wait_cyc(n + 35);

    // ndmreset held for 10 cycles in RUN
    m = cyc;
    ndmreset_i = 1'b1;
    push(1,  "B", 3'd4, 1'b1, 3'b000, 1'b0, 8'd0);
    push(10, "B", 3'd4, 1'b1, 3'b000, 1'b0, 8'd0);
    push(11, "B", 3'd2, 1'b1, 3'b000, 1'b0, 8'd0);
    push(14, "B", 3'd2, 1'b1, 3'b000, 1'b0, 8'd0);
    push(15, "B", 3'd2, 1'b1, 3'b001, 1'b0, 8'd0);
    push(19, "B", 3'd2, 1'b1, 3'b011, 1'b0, 8'd0);
    push(23, "B", 3'd3, 1'b1, 3'b111, 1'b0, 8'd0);
    push(28, "B", 3'd3, 1'b1, 3'b111, 1'b1, 8'd0);
    wait_cyc(m + 10);
    ndmreset_i = 1'b0;
    wait_cyc(m + 30);

    // Single-cycle software reset while heartbeat is high
    p = cyc;
    sw_rst_req_i = 1'b1;
    push(1,  "C", 3'd4, 1'b1, 3'b000, 1'b0, 8'd0);
    push(4,  "C", 3'd4, 1'b1, 3'b000, 1'b0, 8'd0);
    push(5,  "C", 3'd2, 1'b1, 3'b000, 1'b0, 8'd0);
    push(8,  "C", 3'd2, 1'b1, 3'b000, 1'b0, 8'd0);
    push(9,  "C", 3'd2, 1'b1, 3'b001, 1'b0, 8'd0);
    push(13, "C", 3'd2, 1'b1, 3'b011, 1'b0, 8'd0);
    push(17, "C", 3'd3, 1'b1, 3'b111, 1'b0, 8'd0);
    push(21, "C", 3'd3, 1'b1, 3'b111, 1'b0, 8'd0);
    push(22, "C", 3'd3, 1'b1, 3'b111, 1'b1, 8'd0);
    push(26, "C", 3'd3, 1'b1, 3'b111, 1'b1, 8'd0);
    push(27, "C", 3'd3, 1'b1, 3'b111, 1'b0, 8'd0);
    push(32, "C", 3'd3, 1'b1, 3'b111, 1'b1, 8'd0);
    wait_cyc(p + 1);
    sw_rst_req_i = 1'b0;
    wait_cyc(p + 34);

    // Lock loss arriving at the FSM in the same cycle as ndmreset
    q = cyc;
    pll_locked_i = 1'b0;
    push(2, "D", 3'd3, 1'b1, 3'b111, 1'b1, 8'd0);
    push(3, "D", 3'd0, 1'b0, 3'b000, 1'b0, 8'd1);
    push(5, "D", 3'd0, 1'b0, 3'b000, 1'b0, 8'd1);
    wait_cyc(q + 2);
    ndmreset_i = 1'b1;
    wait_cyc(q + 3);
    ndmreset_i = 1'b0;
    wait_cyc(q + 6);

    // Repeated losses in RELEASE drive the counter into saturation
    for (int k = 2; k <= 300; k++) begin
      r = cyc;
      pll_locked_i = 1'b1;
      push(15, "S", 3'd0, 1'b0, 3'b000, 1'b0, (k > 255) ? 8'd255 : 8'(k));
      wait_cyc(r + 12);
      pll_locked_i = 1'b0;
      wait_cyc(r + 16);
    end

    // Asynchronous board reset in RELEASE with rst_no=011
    s = cyc;
    pll_locked_i = 1'b1;
    push(19, "E", 3'd2, 1'b1, 3'b011, 1'b0, 8'd255);
    push(20, "E", 3'd2, 1'b1, 3'b011, 1'b0, 8'd255);
    wait_cyc(s + 20);
    async_q.push_back(mk(0, "X", 3'd0, 1'b0, 3'b000, 1'b0, 8'd0));
    #2;
    sys_rst_n    = 1'b0;
    pll_locked_i = 1'b0;
    @(negedge core_clk);
    push(1, "E", 3'd0, 1'b0, 3'b000, 1'b0, 8'd0);
    wait_cyc(cyc + 1);
    sys_rst_n = 1'b1;
    wait_cyc(cyc + 2);

    // Glitchy lock: one-cycle dropout during FILTER restarts the filter
    g = cyc;
    pll_locked_i = 1'b1;
    push(3,  "F", 3'd1, 1'b0, 3'b000, 1'b0, 8'd0);
    push(7,  "F", 3'd1, 1'b0, 3'b000, 1'b0, 8'd0);
    push(8,  "F", 3'd0, 1'b0, 3'b000, 1'b0, 8'd0);
    push(9,  "F", 3'd1, 1'b0, 3'b000, 1'b0, 8'd0);
    push(16, "F", 3'd1, 1'b0, 3'b000, 1'b0, 8'd0);
    push(17, "F", 3'd2, 1'b1, 3'b000, 1'b0, 8'd0);
    push(21, "F", 3'd2, 1'b1, 3'b001, 1'b0, 8'd0);
    wait_cyc(g + 5);
    pll_locked_i = 1'b0;
    wait_cyc(g + 6);
    pll_locked_i = 1'b1;
    wait_cyc(g + 23);

    repeat (3) @(negedge core_clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      $display("FAIL %c: check booked for cycle %0d never evaluated", e.ph, e.cyc);
    end
    while (async_q.size() > 0) begin
      e = async_q.pop_front();
      total++;
      $display("FAIL %c: async reset check never evaluated", e.ph);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
